// File: rtl/alu_operand_stage_if.sv
// ============================================================================
// Module      : alu_operand_stage_if
// Description : Instruction, ALU, result and host-write bundle for the stage
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface alu_operand_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  instr_valid;
  logic                  instr_ready;
  logic [2:0]            instr_ctrl;
  logic [ADDR_WIDTH-1:0] instr_rs0;
  logic [ADDR_WIDTH-1:0] instr_rs1;
  logic                  instr_imm_sel;
  logic [DATA_WIDTH-1:0] instr_imm;
  logic [ADDR_WIDTH-1:0] instr_rd;
  logic                  instr_we;
  logic [2:0]            alu_ctrl;
  logic [DATA_WIDTH-1:0] alu_in0;
  logic [DATA_WIDTH-1:0] alu_in1;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  result_valid;
  logic [DATA_WIDTH-1:0] result;
  logic                  host_wr_valid;
  logic                  host_wr_ready;
  logic [ADDR_WIDTH-1:0] host_wr_addr;
  logic [DATA_WIDTH-1:0] host_wr_data;

  modport master (
    output instr_valid, instr_ctrl, instr_rs0, instr_rs1, instr_imm_sel,
           instr_imm, instr_rd, instr_we, alu_out,
           host_wr_valid, host_wr_addr, host_wr_data,
    input  instr_ready, alu_ctrl, alu_in0, alu_in1, result_valid, result,
           host_wr_ready
  );

  modport slave (
    input  instr_valid, instr_ctrl, instr_rs0, instr_rs1, instr_imm_sel,
           instr_imm, instr_rd, instr_we, alu_out,
           host_wr_valid, host_wr_addr, host_wr_data,
    output instr_ready, alu_ctrl, alu_in0, alu_in1, result_valid, result,
           host_wr_ready
  );
endinterface

`default_nettype wire

// File: rtl/alu_operand_stage.sv
// ============================================================================
// Module      : alu_operand_stage
// Description : Register file and operand issue for a 1-cycle registered ALU,
//               with write-back forwarding. Optional macro
//               ALU_OPERAND_STAGE_RDBK_EN adds a registered debug read port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_operand_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int NREGS      = 16,
  parameter int ADDR_WIDTH = $clog2(NREGS)
) (
  input  wire logic            clk,
  input  wire logic            reset,
  alu_operand_stage_if.slave   bus
`ifdef ALU_OPERAND_STAGE_RDBK_EN
  ,
  input  wire logic [ADDR_WIDTH-1:0] dbg_rd_addr,
  output logic      [DATA_WIDTH-1:0] dbg_rd_data
`endif
);

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic [2:0]            ctrl_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  we_q;
  logic                  wb_pend;
  logic                  issue;
  logic                  wb_fwd;
  logic                  wb_fire;
  logic                  host_fire;

  assign issue     = bus.instr_valid & ~reset;
  assign wb_fwd    = wb_pend & we_q;
  assign wb_fire   = wb_fwd & (rd_q != '0);
  assign host_fire = bus.host_wr_valid & bus.host_wr_ready;

  function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [ADDR_WIDTH-1:0] a);
    if (a == '0)
      return '0;
    else if (wb_fwd && rd_q == a)
      return bus.alu_out;
    else
      return regs[a];
  endfunction

  assign bus.instr_ready   = ~reset;
  assign bus.host_wr_ready = ~reset & ~wb_fire;
  assign bus.alu_in0       = read_reg(bus.instr_rs0);
  assign bus.alu_in1       = bus.instr_imm_sel ? bus.instr_imm : read_reg(bus.instr_rs1);
  assign bus.alu_ctrl      = ctrl_q;
  assign bus.result_valid  = wb_pend;
  assign bus.result        = bus.alu_out;

  // ctrl/rd/we only update on issue so alu_ctrl holds while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      wb_pend <= 1'b0;
    end else begin
      wb_pend <= issue;
      if (issue) begin
        ctrl_q <= bus.instr_ctrl;
        rd_q   <= bus.instr_rd;
        we_q   <= bus.instr_we;
      end
    end
  end

  assign regs[0] = '0;

  // host_wr_ready excludes write-back cycles, so at most one write lands per entry
  generate
    for (genvar i = 1; i < NREGS; i++) begin : g_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          regs[i] <= '0;
        else if (wb_fire && rd_q == ADDR_WIDTH'(i))
          regs[i] <= bus.alu_out;
        else if (host_fire && bus.host_wr_addr == ADDR_WIDTH'(i))
          regs[i] <= bus.host_wr_data;
      end
    end
  endgenerate

`ifdef ALU_OPERAND_STAGE_RDBK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dbg_rd_data <= '0;
    else
      dbg_rd_data <= regs[dbg_rd_addr];
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Directed self-checking bench with a registered-operand ALU model
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_operand_stage;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_operand_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef ALU_OPERAND_STAGE_RDBK_EN
  logic [AW-1:0] dbg_rd_addr = '0;
  logic [DW-1:0] dbg_rd_data;
`endif

  alu_operand_stage #(.DATA_WIDTH(DW), .NREGS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ALU_OPERAND_STAGE_RDBK_EN
    ,
    .dbg_rd_addr (dbg_rd_addr),
    .dbg_rd_data (dbg_rd_data)
`endif
  );

  // ALU: 0 mov, 1 add, 2 sub, 3 and, 4 signed le, 5 signed ge
  logic [DW-1:0] a_q, b_q;
  always_ff @(posedge clk) begin
    a_q <= bus.alu_in0;
    b_q <= bus.alu_in1;
  end
  always_comb begin
    bus.alu_out = '0;
    case (bus.alu_ctrl)
      3'd0: bus.alu_out = a_q;
      3'd1: bus.alu_out = a_q + b_q;
      3'd2: bus.alu_out = a_q - b_q;
      3'd3: bus.alu_out = a_q & b_q;
      3'd4: bus.alu_out = ($signed(a_q) <= $signed(b_q)) ? 32'd1 : 32'd0;
      3'd5: bus.alu_out = ($signed(a_q) >= $signed(b_q)) ? 32'd1 : 32'd0;
      default: bus.alu_out = '0;
    endcase
  end

  task automatic set_instr(input logic [2:0] ctrl, input logic [AW-1:0] rs0,
                           input logic [AW-1:0] rs1, input logic imm_sel,
                           input logic [DW-1:0] imm, input logic [AW-1:0] rd,
                           input logic we);
    bus.instr_valid   = 1'b1;
    bus.instr_ctrl    = ctrl;
    bus.instr_rs0     = rs0;
    bus.instr_rs1     = rs1;
    bus.instr_imm_sel = imm_sel;
    bus.instr_imm     = imm;
    bus.instr_rd      = rd;
    bus.instr_we      = we;
  endtask

  task automatic idle_instr();
    bus.instr_valid = 1'b0;
    bus.instr_we    = 1'b0;
  endtask

  task automatic host_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.host_wr_valid = 1'b1;
    bus.host_wr_addr  = addr;
    bus.host_wr_data  = data;
    checks++;
    if (bus.host_wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL host_ready_idle addr=%0d got=%b exp=1", addr, bus.host_wr_ready);
    end
    @(negedge clk);
    bus.host_wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.alu_ctrl !== 3'd0 || bus.result_valid !== 1'b0 ||
        bus.instr_ready !== 1'b0 || bus.host_wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got ctrl=%0d rv=%b ir=%b hr=%b exp 0/0/0/0",
               bus.alu_ctrl, bus.result_valid, bus.instr_ready, bus.host_wr_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.instr_ready !== 1'b1 || bus.host_wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got ir=%b hr=%b exp 1/1",
               bus.instr_ready, bus.host_wr_ready);
    end
  endtask

  task automatic test_reset_mid_wb();
    set_instr(3'd1, 4'd0, 4'd0, 1'b1, 32'd5, 4'd3, 1'b1);
    @(negedge clk);
    idle_instr();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.result_valid !== 1'b0 || bus.alu_ctrl !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid_wb_during got rv=%b ctrl=%0d exp 0/0",
               bus.result_valid, bus.alu_ctrl);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.result_valid !== 1'b0 || bus.alu_ctrl !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid_wb_after got rv=%b ctrl=%0d exp 0/0",
               bus.result_valid, bus.alu_ctrl);
    end
    set_instr(3'd0, 4'd3, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    @(negedge clk);
    idle_instr();
    checks++;
    if (bus.result !== 32'd0 || bus.result_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_wb_r3 got result=%0d rv=%b exp 0/1",
               bus.result, bus.result_valid);
    end
  endtask

  task automatic test_host_then_alu();
    host_write(4'd1, 32'd5);
    host_write(4'd2, 32'd7);
    set_instr(3'd1, 4'd1, 4'd2, 1'b0, 32'd0, 4'd4, 1'b1);
    @(negedge clk);
    idle_instr();
    checks++;
    if (bus.result_valid !== 1'b1 || bus.result !== 32'd12 || bus.alu_ctrl !== 3'd1) begin
      failures++;
      $display("FAIL add_result got rv=%b result=%0d ctrl=%0d exp 1/12/1",
               bus.result_valid, bus.result, bus.alu_ctrl);
    end
    @(negedge clk);
    checks++;
    if (bus.result_valid !== 1'b0 || bus.alu_ctrl !== 3'd1) begin
      failures++;
      $display("FAIL idle_hold got rv=%b ctrl=%0d exp 0/1", bus.result_valid, bus.alu_ctrl);
    end
    set_instr(3'd0, 4'd4, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    @(negedge clk);
    idle_instr();
    checks++;
    if (bus.result !== 32'd12 || bus.result_valid !== 1'b1) begin
      failures++;
      $display("FAIL mov_r4 got result=%0d rv=%b exp 12/1", bus.result, bus.result_valid);
    end
  endtask

  task automatic test_back_to_back();
    host_write(4'd1, 32'd10);
    set_instr(3'd2, 4'd1, 4'd0, 1'b1, 32'd3, 4'd1, 1'b1);
    @(negedge clk);
    set_instr(3'd1, 4'd1, 4'd1, 1'b0, 32'd0, 4'd2, 1'b1);
    checks++;
    if (bus.result !== 32'd7) begin
      failures++;
      $display("FAIL b2b_sub got result=%0d exp 7", bus.result);
    end
    @(negedge clk);
    idle_instr();
    checks++;
    if (bus.result !== 32'd14 || bus.result_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_add_fwd got result=%0d rv=%b exp 14/1", bus.result, bus.result_valid);
    end
    @(negedge clk);
    set_instr(3'd0, 4'd2, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    @(negedge clk);
    set_instr(3'd0, 4'd1, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    checks++;
    if (bus.result !== 32'd14) begin
      failures++;
      $display("FAIL b2b_r2 got result=%0d exp 14", bus.result);
    end
    @(negedge clk);
    idle_instr();
    checks++;
    if (bus.result !== 32'd7) begin
      failures++;
      $display("FAIL b2b_r1 got result=%0d exp 7", bus.result);
    end
  endtask

  task automatic test_compare_signed();
    host_write(4'd1, 32'hFFFF_FFFE);
    host_write(4'd2, 32'd1);
    set_instr(3'd4, 4'd1, 4'd2, 1'b0, 32'd0, 4'd0, 1'b0);
    @(negedge clk);
    set_instr(3'd5, 4'd1, 4'd2, 1'b0, 32'd0, 4'd0, 1'b0);
    checks++;
    if (bus.result !== 32'd1) begin
      failures++;
      $display("FAIL cmp_le got result=%0d exp 1", bus.result);
    end
    @(negedge clk);
    idle_instr();
    checks++;
    if (bus.result !== 32'd0) begin
      failures++;
      $display("FAIL cmp_ge got result=%0d exp 0", bus.result);
    end
  endtask

  task automatic test_wb_host_conflict();
    set_instr(3'd1, 4'd0, 4'd0, 1'b1, 32'h55, 4'd5, 1'b1);
    @(negedge clk);
    idle_instr();
    bus.host_wr_valid = 1'b1;
    bus.host_wr_addr  = 4'd6;
    bus.host_wr_data  = 32'h66;
    checks++;
    if (bus.host_wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL conflict_ready_t1 got=%b exp 0", bus.host_wr_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.host_wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL conflict_ready_t2 got=%b exp 1", bus.host_wr_ready);
    end
    @(negedge clk);
    bus.host_wr_valid = 1'b0;
    set_instr(3'd0, 4'd5, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    @(negedge clk);
    set_instr(3'd0, 4'd6, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    checks++;
    if (bus.result !== 32'h55) begin
      failures++;
      $display("FAIL conflict_r5 got=%0h exp 55", bus.result);
    end
    @(negedge clk);
    idle_instr();
    checks++;
    if (bus.result !== 32'h66) begin
      failures++;
      $display("FAIL conflict_r6 got=%0h exp 66", bus.result);
    end
    // r0 targeted by a write-back, then by the host
    set_instr(3'd1, 4'd0, 4'd0, 1'b1, 32'd9, 4'd0, 1'b1);
    @(negedge clk);
    idle_instr();
    host_write(4'd0, 32'h77);
    set_instr(3'd1, 4'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    @(negedge clk);
    idle_instr();
    checks++;
    if (bus.result !== 32'd0) begin
      failures++;
      $display("FAIL r0_zero got=%0h exp 0", bus.result);
    end
  endtask

  task automatic test_same_cycle_host_read();
    bus.host_wr_valid = 1'b1;
    bus.host_wr_addr  = 4'd7;
    bus.host_wr_data  = 32'd9;
    set_instr(3'd0, 4'd7, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    @(negedge clk);
    bus.host_wr_valid = 1'b0;
    set_instr(3'd0, 4'd7, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    checks++;
    if (bus.result !== 32'd0) begin
      failures++;
      $display("FAIL same_cycle_old got=%0d exp 0", bus.result);
    end
    @(negedge clk);
    idle_instr();
    checks++;
    if (bus.result !== 32'd9) begin
      failures++;
      $display("FAIL same_cycle_new got=%0d exp 9", bus.result);
    end
  endtask

`ifdef ALU_OPERAND_STAGE_RDBK_EN
  task automatic test_dbg_read();
    dbg_rd_addr = 4'd7;
    @(negedge clk);
    checks++;
    if (dbg_rd_data !== 32'd9) begin
      failures++;
      $display("FAIL dbg_r7 got=%0d exp 9", dbg_rd_data);
    end
    dbg_rd_addr = 4'd0;
    @(negedge clk);
    checks++;
    if (dbg_rd_data !== 32'd0) begin
      failures++;
      $display("FAIL dbg_r0 got=%0d exp 0", dbg_rd_data);
    end
  endtask
`endif

  initial begin
    bus.instr_valid   = 1'b0;
    bus.instr_ctrl    = '0;
    bus.instr_rs0     = '0;
    bus.instr_rs1     = '0;
    bus.instr_imm_sel = 1'b0;
    bus.instr_imm     = '0;
    bus.instr_rd      = '0;
    bus.instr_we      = 1'b0;
    bus.host_wr_valid = 1'b0;
    bus.host_wr_addr  = '0;
    bus.host_wr_data  = '0;
    test_reset();
    test_reset_mid_wb();
    test_host_then_alu();
    test_back_to_back();
    test_compare_signed();
    test_wb_host_conflict();
    test_same_cycle_host_read();
`ifdef ALU_OPERAND_STAGE_RDBK_EN
    test_dbg_read();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
